// File: rtl/grey_stream_tx.sv
// grey_stream_tx: buffers upstream pixels in a small FIFO and forwards exactly one IMG_W*IMG_H frame per start.
// Latency: a pixel pushed into an empty FIFO is presented downstream the cycle after the push edge.
// Backpressure: i_pix_busy is asserted when the FIFO is full or outside RUN; o_grey_busy holds the FIFO head.
//
// Ports:
//   i_clk, i_rst            : clock, asynchronous active-high reset
//   start                   : one-cycle frame request, honoured only in IDLE
//   i_pix_vld/_data/_busy   : upstream busy/valid pixel channel (word moves when vld & !busy)
//   o_grey_vld/_data/_busy  : downstream busy/valid pixel channel (word moves when vld & !busy)
//   active                  : frame in progress
//   frame_done              : one-cycle pulse after the final downstream transfer
//   tx_cnt                  : downstream transfers in the current or last frame

// grey_stream_fifo: DEPTH-entry FIFO with wrapping pointers plus a lap bit for full/empty.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: no internal guarding; the owner must not push when full or pop when empty.
module grey_stream_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              push_vld,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop_vld,
  output logic [DATA_W-1:0] head_dat,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_vld) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop_vld) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      foreach (mem_q[i]) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // Same index with differing lap bits means the writer is a full lap ahead.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Empty FIFO presents zero rather than stale storage.
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

module grey_stream_tx #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 4,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                start,
  input  logic                                i_pix_vld,
  input  logic [DATA_W-1:0]                   i_pix_data,
  output logic                                i_pix_busy,
  input  logic                                o_grey_busy,
  output logic                                o_grey_vld,
  output logic [DATA_W-1:0]                   o_grey_data,
  output logic                                active,
  output logic                                frame_done,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0]    tx_cnt
);

  localparam int              TOTAL    = IMG_W * IMG_H;
  localparam int              CNT_W    = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] TOTAL_M1 = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  grey_stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .push_vld (fifo_push),
    .push_dat (i_pix_data),
    .pop_vld  (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Upstream busy comes only from state and occupancy, so a full FIFO blocks
  // the push even on a cycle where a pop frees a slot.
  assign i_pix_busy  = (state_q != S_RUN) || fifo_full;
  assign fifo_push   = i_pix_vld && !i_pix_busy;

  assign o_grey_vld  = !fifo_empty;
  assign o_grey_data = fifo_head;
  assign fifo_pop    = o_grey_vld && !o_grey_busy;

  assign active      = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_DONE);
  assign tx_cnt      = tx_cnt_q;

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    tx_cnt_d  = tx_cnt_q;

    if (fifo_pop) begin
      tx_cnt_d = tx_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        // FIFO is always empty here, so clearing tx_cnt cannot race a pop.
        if (start) begin
          state_d   = S_RUN;
          acc_cnt_d = '0;
          tx_cnt_d  = '0;
        end
      end
      S_RUN: begin
        if (fifo_push) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (acc_cnt_q == TOTAL_M1) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((tx_cnt_q == TOTAL_C) && fifo_empty) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      acc_cnt_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
    end
  end

endmodule

// File: doc/grey_stream_tx.md
# grey_stream_tx

Transmitter for the grey-pixel busy/valid point-to-point channel consumed by `ImageGradient` on its `i_grey_*` port. It accepts raw 24-bit pixels from an upstream busy/valid source and buffers them in a small FIFO. It forwards exactly one frame (`IMG_W*IMG_H` pixels) per `start` pulse in raster order, honouring downstream `busy` back-pressure, then signals frame completion. It sits between the frame loader and the gradient engine.

## Interface
- `DATA_W`, 24: pixel word width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `IMG_W`, 256: pixels per row.
- `IMG_H`, 256: rows per frame.
- `i_clk` in 1: single clock, rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle frame start request.
- `i_pix_vld` in 1: upstream pixel valid.
- `i_pix_data` in DATA_W: upstream pixel.
- `i_pix_busy` out 1: block cannot accept a pixel this cycle.
- `o_grey_busy` in 1: downstream (gradient engine) stalled.
- `o_grey_vld` out 1: pixel presented downstream.
- `o_grey_data` out DATA_W: presented pixel.
- `active` out 1: frame in progress (state ≠ IDLE).
- `frame_done` out 1: one-cycle pulse after the last pixel is transferred downstream.
- `tx_cnt` out clog2(IMG_W*IMG_H+1): pixels transferred downstream in the current or last frame.

## Operation
- Transfer rule on both channels: a word moves on a rising edge where `vld=1` and `busy=0`.
- Reset values: `i_pix_busy=1`, `o_grey_vld=0`, `o_grey_data=0`, `active=0`, `frame_done=0`, `tx_cnt=0`. Reset also sets FIFO empty, accept count 0, and state IDLE.
- Let TOTAL = IMG_W*IMG_H. `acc_cnt` counts upstream transfers and `tx_cnt` counts downstream transfers.
- State IDLE:
  - `i_pix_busy=1`.
  - `start` → RUN, clearing `acc_cnt` and `tx_cnt` on the same edge.
- State RUN:
  - `i_pix_busy = fifo_full`.
  - On each upstream transfer, push the pixel and increment `acc_cnt`.
  - When the push makes `acc_cnt==TOTAL` → DRAIN.
- State DRAIN:
  - `i_pix_busy=1`; downstream pops continue.
  - When `tx_cnt==TOTAL` and the FIFO is empty → DONE.
- State DONE: `frame_done=1` for exactly one cycle, then → IDLE. `tx_cnt` holds TOTAL until the next `start`.
- `start` while not in IDLE is ignored. There is no queueing.
- `o_grey_vld = !fifo_empty`. `o_grey_data` = FIFO head; it is 0 when the FIFO is empty.
- While `o_grey_vld=1 && o_grey_busy=1`, `o_grey_vld` and `o_grey_data` must stay stable; the head is not advanced.
- `i_pix_busy` depends only on state and FIFO occupancy. It is never combinationally driven from `o_grey_busy`.
- FIFO has `DEPTH` entries with wrapping read/write pointers plus one extra bit for full/empty.
- Simultaneous push and pop:
  - Occupancy is unchanged and both pointers advance.
  - When full, the push is blocked that cycle because `i_pix_busy=1`, even if a pop occurs.
  - When empty, the pop cannot happen because `vld=0`.
- Extra upstream pixels offered after TOTAL are not accepted (`i_pix_busy=1` in DRAIN, DONE and IDLE).
- Reset asserted mid-frame aborts immediately: FIFO contents are discarded, outputs take their reset values, and no `frame_done` is generated.

## Timing
- Latency: a pixel pushed into an empty FIFO at edge N is visible on `o_grey_vld`/`o_grey_data` in the cycle after edge N. It can transfer downstream at edge N+1.
- No combinational path from any input to `o_grey_vld`, `o_grey_data` or `i_pix_busy`; all are derived from registered state.
- With `o_grey_busy=0` and `i_pix_vld=1` continuously, throughput is 1 pixel/cycle.
- Timing of the final pixel and the completion pulse:
  - Edge E: last downstream transfer.
  - Edge E+1: state reaches DONE.
  - Cycle after E+1: `frame_done=1`, `active=1`.
  - Following cycle: `active=0`.
- `tx_cnt` updates on the same edge as each downstream transfer.

## Test plan
- **Basic frame** (IMG_W=4, IMG_H=2, DEPTH=4): pulse `start`, feed pixels 0x000001..0x000008 back-to-back with `o_grey_busy=0`.
  - Downstream receives 0x000001..0x000008 in order at 1/cycle.
  - `frame_done` pulses once, then `tx_cnt=8`.
- **Back-pressure**: same frame with `o_grey_busy=1` throughout.
  - After 4 accepts, `i_pix_busy=1` and `o_grey_vld=1` with data held at 0x000001.
  - Release busy: all 8 pixels delivered in order with no loss or duplication.
- **Random stalls**: random `i_pix_vld` and `o_grey_busy` over 3 consecutive frames.
  - Output sequence equals input sequence.
  - Exactly 3 `frame_done` pulses.
  - `o_grey_data` never changes while `vld && busy`.
- **Start ignored and over-supply**:
  - A second `start` mid-frame has no effect.
  - A 9th upstream pixel is offered but never accepted; `i_pix_busy=1` after the 8th accept.
- **Reset mid-frame**: assert `i_rst` after 3 downstream transfers.
  - All outputs return to reset values asynchronously; no `frame_done`.
  - A new `start` delivers a full fresh frame of 8 pixels.
- **Full with simultaneous pop**: with the FIFO full, deassert `o_grey_busy` for one cycle.
  - One pop occurs; no push that cycle.
  - The push occurs on the next edge; occupancy returns to 4.
